// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : UART transmit engine. Pops bytes from the TX FIFO and sends
//                each one on txd as start, DATA_W data bits (LSB first), an
//                optional parity bit, and one or two stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_pop,
    output logic              txd,
    output logic              busy,
    output logic              tx_done
);

    // The index counts data bits and also the second stop bit, so it must hold
    // values up to DATA_W-1 and at least 1.
    localparam int IDX_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state_q,   w_state_d;
    logic [DIV_W-1:0]  r_cnt_q,     w_cnt_d;
    logic [IDX_W-1:0]  r_idx_q,     w_idx_d;
    logic [DATA_W-1:0] r_shift_q,   w_shift_d;
    logic [DIV_W-1:0]  r_div_q,     w_div_d;
    logic              r_par_en_q,  w_par_en_d;
    logic              r_par_bit_q, w_par_bit_d;
    logic              r_stop2_q,   w_stop2_d;
    logic              r_txd_q,     w_txd_d;
    logic              r_busy_q,    w_busy_d;
    logic              r_done_q,    w_done_d;

    logic              w_can_launch;
    logic              w_launch;
    logic              w_bit_end;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_idx_d     = r_idx_q;
        w_shift_d   = r_shift_q;
        w_div_d     = r_div_q;
        w_par_en_d  = r_par_en_q;
        w_par_bit_d = r_par_bit_q;
        w_stop2_d   = r_stop2_q;
        w_done_d    = 1'b0;
        w_launch    = 1'b0;
        w_txd_d     = 1'b1;
        w_busy_d    = 1'b0;

        // The pop must coincide with taking fifo_rdata, so it is decided in
        // the same cycle from the current state and FIFO occupancy; it is
        // held off while reset is asserted.
        w_can_launch = enable && (fifo_count != '0) && !rst;
        w_bit_end    = (r_cnt_q == '0);

        case (r_state_q)
            S_IDLE: begin
                if (w_can_launch) begin
                    w_launch = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_d = S_DATA;
                    w_cnt_d   = r_div_q;
                    w_idx_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_d = r_shift_q >> 1;
                    w_cnt_d   = r_div_q;
                    if (r_idx_q == IDX_W'(DATA_W - 1)) begin
                        w_idx_d   = '0;
                        w_state_d = r_par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_d = r_idx_q + IDX_W'(1);
                    end
                end else begin
                    w_cnt_d = r_cnt_q - DIV_W'(1);
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_d = S_STOP;
                    w_cnt_d   = r_div_q;
                    w_idx_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stop2_q && (r_idx_q == '0)) begin
                        // First of two stop bits just ended.
                        w_idx_d = IDX_W'(1);
                        w_cnt_d = r_div_q;
                    end else begin
                        // Final stop bit: chain straight into the next frame
                        // when a byte is waiting, with no idle gap.
                        w_done_d = 1'b1;
                        if (w_can_launch) begin
                            w_launch = 1'b1;
                        end else begin
                            w_state_d = S_IDLE;
                        end
                    end
                end else begin
                    w_cnt_d = r_cnt_q - DIV_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Launch captures the byte and the whole line configuration so later
        // changes to the inputs cannot disturb a frame already in flight.
        if (w_launch) begin
            w_state_d   = S_START;
            w_shift_d   = fifo_rdata;
            w_div_d     = clk_div;
            w_cnt_d     = clk_div;
            w_par_en_d  = parity_en;
            w_par_bit_d = (^fifo_rdata) ^ parity_odd;
            w_stop2_d   = stop2;
            w_idx_d     = '0;
        end

        // Line level and busy are registered from the state being entered.
        case (w_state_d)
            S_START:  w_txd_d = 1'b0;
            S_DATA:   w_txd_d = w_shift_d[0];
            S_PARITY: w_txd_d = r_par_bit_q;
            default:  w_txd_d = 1'b1;
        endcase
        w_busy_d = (w_state_d != S_IDLE);
    end

    // State and output registers; reset abandons any frame at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_idx_q     <= '0;
            r_shift_q   <= '0;
            r_div_q     <= '0;
            r_par_en_q  <= 1'b0;
            r_par_bit_q <= 1'b0;
            r_stop2_q   <= 1'b0;
            r_txd_q     <= 1'b1;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_idx_q     <= w_idx_d;
            r_shift_q   <= w_shift_d;
            r_div_q     <= w_div_d;
            r_par_en_q  <= w_par_en_d;
            r_par_bit_q <= w_par_bit_d;
            r_stop2_q   <= w_stop2_d;
            r_txd_q     <= w_txd_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
        end
    end

    assign fifo_pop = w_launch;
    assign txd      = r_txd_q;
    assign busy     = r_busy_q;
    assign tx_done  = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_serializer
//  Description : Self-checking bench for uart_tx_serializer: table of single
//                frames plus back-to-back, reset and enable-drop sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [DIV_W-1:0]  clk_div;
    logic              parity_en;
    logic              parity_odd;
    logic              stop2;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_pop;
    logic              txd;
    logic              busy;
    logic              tx_done;

    int total = 0;
    int bad   = 0;

    // Small FIFO model feeding the DUT.
    logic [7:0] mem [16];
    int         wr = 0;
    int         rd = 0;

    assign fifo_count = CNT_W'(wr - rd);
    assign fifo_rdata = mem[rd[3:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_pop) rd <= rd + 1;
    end

    uart_tx_serializer #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clk_div    (clk_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .fifo_count (fifo_count),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // frame holds the wire bits in transmit order starting at bit 11.
    typedef struct {
        logic [7:0]       data;
        logic [DIV_W-1:0] div;
        logic             pen;
        logic             podd;
        logic             s2;
        logic [11:0]      frame;
        int               nbits;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr[3:0]] = d;
        wr = wr + 1;
    endtask

    task automatic run_vec(input vec_t v);
        drive_edge();
        clk_div    = v.div;
        parity_en  = v.pen;
        parity_odd = v.podd;
        stop2      = v.s2;
        push(v.data);
        enable     = 1'b1;
        sample();
        check("launch_pop", fifo_pop, 1);
        for (int k = 0; k < v.nbits; k++) begin
            for (int c = 0; c <= int'(v.div); c++) begin
                drive_edge();
                if (k == 0 && c == 0) begin
                    // Scramble the configuration; the frame must not notice.
                    clk_div    = v.div + DIV_W'(5);
                    parity_en  = ~v.pen;
                    parity_odd = ~v.podd;
                    stop2      = ~v.s2;
                end
                sample();
                check("frame_txd", txd, v.frame[11-k]);
                check("frame_busy", busy, 1);
                check("frame_done", tx_done, 0);
                check("frame_pop", fifo_pop, 0);
            end
        end
        drive_edge();
        sample();
        check("end_done", tx_done, 1);
        check("end_busy", busy, 0);
        check("end_txd", txd, 1);
        drive_edge();
        enable = 1'b0;
        sample();
        check("done_width", tx_done, 0);
    endtask

    initial begin
        int         pops;
        int         n;
        logic [19:0] bb;

        rst        = 1'b0;
        enable     = 1'b0;
        clk_div    = '0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;

        //                data   div  pen podd s2  frame (transmit order)     bits
        vecs[0] = '{8'hA5, 16'd3, 0, 0, 0, 12'b0_10100101_1_00,  10};
        vecs[1] = '{8'h07, 16'd1, 1, 0, 0, 12'b0_11100000_1_1_0, 11};
        vecs[2] = '{8'h07, 16'd1, 1, 1, 0, 12'b0_11100000_0_1_0, 11};
        vecs[3] = '{8'h3C, 16'd2, 0, 0, 1, 12'b0_00111100_1_1_0, 11};
        vecs[4] = '{8'h00, 16'd0, 1, 0, 0, 12'b0_00000000_0_1_0, 11};
        vecs[5] = '{8'h80, 16'd0, 1, 1, 1, 12'b0_00000001_0_1_1, 12};

        #2 rst = 1'b1;
        sample();
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_done", tx_done, 0);
        drive_edge();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back frames at one cycle per bit.
        bb = 20'b0_00000000_1_0_11111111_1;
        drive_edge();
        clk_div    = '0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        push(8'h00);
        push(8'hFF);
        enable     = 1'b1;
        sample();
        check("b2b_pop1", fifo_pop, 1);
        for (int j = 1; j <= 21; j++) begin
            drive_edge();
            sample();
            if (j <= 20) begin
                check("b2b_txd", txd, bb[20-j]);
                check("b2b_busy", busy, 1);
                check("b2b_pop", fifo_pop, (j == 10) ? 1 : 0);
                check("b2b_done", tx_done, (j == 11) ? 1 : 0);
            end else begin
                check("b2b_end_done", tx_done, 1);
                check("b2b_end_busy", busy, 0);
                check("b2b_end_txd", txd, 1);
            end
        end
        drive_edge();
        enable = 1'b0;
        sample();

        // Reset during data bit 3, then release with an empty FIFO.
        drive_edge();
        clk_div = 16'd3;
        push(8'h52);
        enable  = 1'b1;
        sample();
        check("rstm_pop", fifo_pop, 1);
        for (int j = 1; j <= 17; j++) begin
            drive_edge();
            sample();
        end
        check("rstm_pre_txd", txd, 0);
        check("rstm_pre_busy", busy, 1);
        drive_edge();
        rst = 1'b1;
        #1;
        check("rstm_txd", txd, 1);
        check("rstm_busy", busy, 0);
        check("rstm_pop_in_rst", fifo_pop, 0);
        drive_edge();
        drive_edge();
        rst = 1'b0;
        pops = 0;
        for (int j = 0; j < 100; j++) begin
            drive_edge();
            sample();
            pops += int'(fifo_pop);
        end
        check("rstm_no_pop", pops, 0);
        check("rstm_idle_busy", busy, 0);
        check("rstm_idle_txd", txd, 1);
        enable = 1'b0;

        // Enable dropped mid-frame with three bytes queued.
        drive_edge();
        clk_div = '0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        enable  = 1'b1;
        sample();
        check("endrop_pop", fifo_pop, 1);
        pops = 0;
        for (int j = 1; j <= 14; j++) begin
            drive_edge();
            if (j == 3) enable = 1'b0;
            sample();
            pops += int'(fifo_pop);
            if (j == 11) begin
                check("endrop_done", tx_done, 1);
                check("endrop_busy", busy, 0);
            end
        end
        check("endrop_extra_pops", pops, 0);
        check("endrop_count", fifo_count, 2);
        drive_edge();
        enable = 1'b1;
        sample();
        check("reen_pop", fifo_pop, 1);
        drive_edge();
        enable = 1'b0;
        sample();
        check("reen_txd", txd, 0);
        check("reen_busy", busy, 1);
        n = 0;
        while (busy && n < 40) begin
            drive_edge();
            sample();
            n++;
        end
        check("reen_drain", busy, 0);
        check("reen_count", fifo_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
